// File: rtl/snow64_memory_bus_guard.sv
// snow64_memory_bus_guard
// Arbitrates between one read client and one write client in front of a
// single memory bus.  Only one transaction is in flight at a time; every
// output comes straight from a flop.
module snow64_memory_bus_guard #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_cmd_accepted,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_cmd_accepted,
    output logic                  wr_valid,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_RESPOND   = 2'd3;

    logic [1:0] state;
    logic       last_wr;   // 1 = write client was served most recently
    logic       pick_wr;   // client chosen if a capture happens this cycle

    // Arbitration: a lone requester wins; on a tie the client not served last wins.
    always_comb begin
        pick_wr = wr_req;
        if (rd_req && wr_req)
            pick_wr = !last_wr;
    end

    // Transaction sequencer.  mem_we stays valid for the whole transaction
    // and doubles as the "current transaction is a write" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            last_wr         <= 1'b1;
            rd_cmd_accepted <= 1'b0;
            wr_cmd_accepted <= 1'b0;
            rd_valid        <= 1'b0;
            wr_valid        <= 1'b0;
            rd_data         <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
        end else begin
            // Handshake pulses last a single cycle unless re-asserted below.
            rd_cmd_accepted <= 1'b0;
            wr_cmd_accepted <= 1'b0;
            rd_valid        <= 1'b0;
            wr_valid        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req || wr_req) begin
                        state           <= ST_ISSUE;
                        last_wr         <= pick_wr;
                        mem_req         <= 1'b1;
                        mem_we          <= pick_wr;
                        mem_addr        <= pick_wr ? wr_addr : rd_addr;
                        if (pick_wr)
                            mem_wdata   <= wr_data;
                        rd_cmd_accepted <= !pick_wr;
                        wr_cmd_accepted <= pick_wr;
                    end
                end
                ST_ISSUE: begin
                    // Command is held stable until memory takes it; any
                    // mem_valid seen here is stale and ignored.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem_valid) begin
                        if (!mem_we)
                            rd_data <= mem_rdata;
                        rd_valid <= !mem_we;
                        wr_valid <= mem_we;
                        state    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    // Completion pulse is visible this cycle; requests are
                    // not looked at again until IDLE.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snow64_memory_bus_guard.sv
// Self-checking bench for snow64_memory_bus_guard.  The bench plays both
// clients and the memory; a transaction-level model (winner selection from
// the tie-break rule, expected read line) predicts every observed value.
module tb_snow64_memory_bus_guard;

    localparam int AW = 64;
    localparam int DW = 256;

    logic          clk, rst;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_cmd_accepted, rd_valid, wr_cmd_accepted, wr_valid;
    logic          mem_req, mem_we, mem_ready, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    snow64_memory_bus_guard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_cmd_accepted(rd_cmd_accepted),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_cmd_accepted(wr_cmd_accepted), .wr_valid(wr_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    bit            last_wr;    // last client served was the writer
    logic [DW-1:0] exp_rd;     // line rd_data must be showing

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {rd_cmd_accepted, rd_valid, wr_cmd_accepted, wr_valid, mem_req, mem_we}, '0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    // One complete transaction, starting and ending on a falling edge with
    // the DUT idle.  rdly = cycles mem_ready stays low, vdly = cycles before
    // mem_valid, spur = stale mem_valid pulse while the command is pending,
    // hold = requests stay high one cycle past cmd_accepted.
    task automatic txn(input bit r, input bit w, input bit hold, input int rdly, input int vdly,
                       input bit spur, input logic [AW-1:0] raddr, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        bit is_wr;
        is_wr   = (r && w) ? !last_wr : w;
        last_wr = is_wr;
        rd_req = r; wr_req = w; rd_addr = raddr; wr_addr = waddr; wr_data = wdata;
        mem_ready = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        // cycle 1: command captured
        chk("rd_cmd_accepted", rd_cmd_accepted, !is_wr);
        chk("wr_cmd_accepted", wr_cmd_accepted, is_wr);
        chk("mem_we", mem_we, is_wr);
        chk("mem_addr", mem_addr, is_wr ? waddr : raddr);
        if (is_wr) chk("mem_wdata", mem_wdata, wdata);
        if (!hold) begin rd_req = 1'b0; wr_req = 1'b0; end
        for (int k = 0; k <= rdly; k++) begin
            chk("mem_req_issue", mem_req, 1'b1);
            chk("valid_issue", {rd_valid, wr_valid}, 2'b00);
            if (k > 0) chk("cmd_acc_issue", {rd_cmd_accepted, wr_cmd_accepted}, 2'b00);
            mem_ready = (k == rdly);
            mem_valid = spur && (k == 0) && (rdly > 0);
            mem_rdata = rand_line();
            @(negedge clk);
            if (hold) begin rd_req = 1'b0; wr_req = 1'b0; hold = 1'b0; end
        end
        mem_ready = 1'b0;
        for (int k = 0; k <= vdly; k++) begin
            chk("mem_req_wait", mem_req, 1'b0);
            chk("valid_wait", {rd_valid, wr_valid, rd_cmd_accepted, wr_cmd_accepted}, 4'b0);
            mem_valid = (k == vdly);
            mem_rdata = (k == vdly) ? rdata : rand_line();
            @(negedge clk);
        end
        mem_valid = 1'b0;
        mem_rdata = rand_line();
        if (!is_wr) exp_rd = rdata;
        chk("rd_valid", rd_valid, !is_wr);
        chk("wr_valid", wr_valid, is_wr);
        chk("rd_data", rd_data, exp_rd);
        @(negedge clk);
        chk("post_idle", {rd_valid, wr_valid, rd_cmd_accepted, wr_cmd_accepted, mem_req}, 5'b0);
        chk("rd_data_hold", rd_data, exp_rd);
    endtask

    initial begin
        rst = 1'b1;
        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        mem_ready = 0; mem_valid = 0; mem_rdata = '0;
        last_wr = 1'b1; exp_rd = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // single read at minimum latency
        txn(1, 0, 0, 0, 0, 0, 64'h1000, '0, '0, {32{8'hA5}});
        // single write, memory stalls 4 cycles
        txn(0, 1, 0, 4, 1, 0, '0, 64'h2000, {32{8'h5A}}, rand_line());

        // reset while waiting for the response abandons the transaction
        rd_req = 1'b1; rd_addr = 64'h3000;
        @(negedge clk);
        rd_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0; last_wr = 1'b1; exp_rd = '0;
        mem_valid = 1'b1; mem_rdata = rand_line();
        @(negedge clk);
        mem_valid = 1'b0;
        chk_all_zero("late_valid");
        @(negedge clk);
        chk_all_zero("late_valid2");

        // simultaneous requests alternate starting with the read
        for (int i = 0; i < 4; i++)
            txn(1, 1, 0, $urandom_range(0, 2), $urandom_range(0, 2), 0,
                rand_addr(), rand_addr(), rand_line(), rand_line());
        // stale mem_valid while command pending, for each direction
        txn(1, 0, 0, 2, 1, 1, rand_addr(), rand_addr(), rand_line(), rand_line());
        txn(0, 1, 0, 3, 0, 1, rand_addr(), rand_addr(), rand_line(), rand_line());
        // request held one cycle past accept: single command
        txn(1, 0, 1, 0, 0, 0, rand_addr(), rand_addr(), rand_line(), rand_line());
        txn(0, 1, 1, 0, 2, 0, rand_addr(), rand_addr(), rand_line(), rand_line());

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                rand_addr(), rand_addr(), rand_line(), rand_line());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
